// File: rtl/core_pkg.sv
// Core-wide decode constants shared by the control decoder, ALU control and
// hazard controller.
package core_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_IMM = 7'b0010011;
    localparam logic [6:0] OP_I_LW  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_SB    = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IMM   = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        CTRL_RESET,
        CTRL_FREEZE,
        CTRL_BUBBLE,
        CTRL_FLUSH,
        CTRL_RUN
    } ctrl_mode_e;

    // x0 is hardwired to zero, so it can never carry a dependence.
    function automatic logic reg_match(input logic [4:0] x,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2,
                                       input logic       uses_rs1,
                                       input logic       uses_rs2);
        return (x != 5'd0) && ((uses_rs1 && (x == rs1)) || (uses_rs2 && (x == rs2)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard control bundle: instruction fields in, pipeline controls
// and performance counters out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [6:0]       Op_i;
    logic [4:0]       RS1addr_i;
    logic [4:0]       RS2addr_i;
    logic [4:0]       RDaddr_i;
    logic             BranchTaken_i;
    logic             MemStall_i;
    logic             NoOp_o;
    logic             PCWrite_o;
    logic             Stall_o;
    logic             Flush_o;
    logic             Freeze_o;
    logic [CNT_W-1:0] BubbleCnt_o;
    logic [CNT_W-1:0] FlushCnt_o;

    modport master (
        output Op_i, RS1addr_i, RS2addr_i, RDaddr_i, BranchTaken_i, MemStall_i,
        input  NoOp_o, PCWrite_o, Stall_o, Flush_o, Freeze_o, BubbleCnt_o, FlushCnt_o
    );

    modport slave (
        input  Op_i, RS1addr_i, RS2addr_i, RDaddr_i, BranchTaken_i, MemStall_i,
        output NoOp_o, PCWrite_o, Stall_o, Flush_o, Freeze_o, BubbleCnt_o, FlushCnt_o
    );
endinterface

// File: rtl/hazard_ctrl_op_decode.sv
// Opcode-class decode for the hazard controller: which register fields the
// ID instruction reads and writes.
module hazard_op_decode
    import core_pkg::*;
(
    input  logic [6:0] op_i,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o,
    output logic       writes_rd_o,
    output logic       is_load_o,
    output logic       is_branch_o
);

    always_comb begin
        uses_rs1_o  = 1'b0;
        uses_rs2_o  = 1'b0;
        writes_rd_o = 1'b0;
        is_load_o   = 1'b0;
        is_branch_o = 1'b0;
        case (op_i)
            OP_R: begin
                uses_rs1_o  = 1'b1;
                uses_rs2_o  = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_I_IMM: begin
                uses_rs1_o  = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_I_LW: begin
                uses_rs1_o  = 1'b1;
                writes_rd_o = 1'b1;
                is_load_o   = 1'b1;
            end
            OP_S: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
            end
            OP_SB: begin
                uses_rs1_o  = 1'b1;
                uses_rs2_o  = 1'b1;
                is_branch_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: shadows EX/MEM destination state, detects
// load-use and branch-operand hazards, and drives stall/flush/freeze.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  hz
);

    logic uses_rs1, uses_rs2, writes_rd, is_load, is_branch;

    hazard_op_decode u_op_decode (
        .op_i        (hz.Op_i),
        .uses_rs1_o  (uses_rs1),
        .uses_rs2_o  (uses_rs2),
        .writes_rd_o (writes_rd),
        .is_load_o   (is_load),
        .is_branch_o (is_branch)
    );

    logic [4:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
    logic             ex_rw_q, ex_rw_d, ex_mr_q, ex_mr_d, mem_mr_q, mem_mr_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;

    logic       ex_match, mem_match, load_use, br_haz, hazard;
    ctrl_mode_e mode;
    logic       noop, pc_write, stall, flush, freeze;

    always_comb begin
        ex_match  = reg_match(ex_rd_q, hz.RS1addr_i, hz.RS2addr_i, uses_rs1, uses_rs2);
        mem_match = reg_match(mem_rd_q, hz.RS1addr_i, hz.RS2addr_i, uses_rs1, uses_rs2);
        load_use  = ex_mr_q && ex_match;
        br_haz    = is_branch && ((ex_rw_q && ex_match) || (mem_mr_q && mem_match));
        hazard    = load_use || br_haz;
    end

    // Taken branches are only honoured once no hazard remains: their
    // comparator operands would otherwise be stale.
    always_comb begin
        if (!rst_i)                mode = CTRL_RESET;
        else if (hz.MemStall_i)    mode = CTRL_FREEZE;
        else if (hazard)           mode = CTRL_BUBBLE;
        else if (hz.BranchTaken_i) mode = CTRL_FLUSH;
        else                       mode = CTRL_RUN;
    end

    always_comb begin
        noop     = 1'b0;
        pc_write = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        freeze   = 1'b0;
        case (mode)
            CTRL_RESET:  noop = 1'b1;
            CTRL_FREEZE: begin
                freeze = 1'b1;
                stall  = 1'b1;
            end
            CTRL_BUBBLE: begin
                noop  = 1'b1;
                stall = 1'b1;
            end
            CTRL_FLUSH: begin
                flush    = 1'b1;
                pc_write = 1'b1;
            end
            default:     pc_write = 1'b1;
        endcase
    end

    always_comb begin
        ex_rd_d      = ex_rd_q;
        ex_rw_d      = ex_rw_q;
        ex_mr_d      = ex_mr_q;
        mem_rd_d     = mem_rd_q;
        mem_mr_d     = mem_mr_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!freeze) begin
            mem_rd_d = ex_rd_q;
            mem_mr_d = ex_mr_q;
            if (noop) begin
                ex_rd_d = '0;
                ex_rw_d = 1'b0;
                ex_mr_d = 1'b0;
            end else begin
                ex_rd_d = hz.RDaddr_i;
                ex_rw_d = writes_rd;
                ex_mr_d = is_load;
            end
            if (noop && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != '1))  flush_cnt_d  = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_rd_q      <= '0;
            ex_rw_q      <= 1'b0;
            ex_mr_q      <= 1'b0;
            mem_rd_q     <= '0;
            mem_mr_q     <= 1'b0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_rd_q      <= ex_rd_d;
            ex_rw_q      <= ex_rw_d;
            ex_mr_q      <= ex_mr_d;
            mem_rd_q     <= mem_rd_d;
            mem_mr_q     <= mem_mr_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign hz.NoOp_o      = noop;
    assign hz.PCWrite_o   = pc_write;
    assign hz.Stall_o     = stall;
    assign hz.Flush_o     = flush;
    assign hz.Freeze_o    = freeze;
    assign hz.BubbleCnt_o = bubble_cnt_q;
    assign hz.FlushCnt_o  = flush_cnt_q;

endmodule
